// File: rtl/wdrc_envelope_detector.sv
// wdrc_envelope_detector: rectifies a signed band sample and smooths it with a one-pole
// attack/release follower over a 4-cycle FSM. Define ENV_PEAK_HOLD_EN for release peak hold.
module wdrc_envelope_detector #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int COEF_W = 8,
  parameter int HOLD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] audio_in,
  input  logic [COEF_W-1:0] attack_coef,
  input  logic [COEF_W-1:0] release_coef,
  input  logic [HOLD_W-1:0] hold_samples,
  output logic              env_valid,
  output logic [DATA_W-1:0] env_out
);
  localparam int ACC_W  = DATA_W + FRAC_W;
  localparam int DIFF_W = ACC_W + 1;
  localparam int PROD_W = DIFF_W + COEF_W + 1;
  localparam int SUM_W  = DIFF_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    MUL  = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic                      accept_s;
  logic signed [DATA_W-1:0]  sample_r;
  logic        [COEF_W-1:0]  atk_r;
  logic        [COEF_W-1:0]  rel_r;
  logic        [COEF_W-1:0]  coef_sel_r;
  logic        [ACC_W-1:0]   acc_r;
  logic signed [DIFF_W-1:0]  diff_r;
  logic signed [DIFF_W-1:0]  step_r;
  logic        [DATA_W-1:0]  env_out_r;
  logic                      env_valid_r;
  logic        [DATA_W-1:0]  mag_s;
  logic signed [DIFF_W-1:0]  diff_s;
  logic                      diff_pos_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [DIFF_W-1:0]  step_raw_s;
  logic signed [DIFF_W-1:0]  step_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic        [ACC_W-1:0]   acc_nxt_s;
  logic                      hold_block_s;

  // Magnitude with the most negative code saturated to the largest positive code.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x[DATA_W-1] == 1'b0) begin
      abs_sat = x;
    end else if (x[DATA_W-2:0] == {(DATA_W-1){1'b0}}) begin
      abs_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      abs_sat = -x;
    end
  endfunction

  assign accept_s = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic: fixed IDLE->ABS->MUL->UPD ring.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ABS;
        else          state_nxt_s = IDLE;
      end
      ABS:     state_nxt_s = MUL;
      MUL:     state_nxt_s = UPD;
      UPD:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake output; held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && enable && (state_r == IDLE)) in_ready = 1'b1;
    else                                      in_ready = 1'b0;
  end

  // Datapath arithmetic for the ABS, MUL and UPD stages.
  always_comb begin
    mag_s      = abs_sat(sample_r);
    diff_s     = $signed({1'b0, mag_s, {FRAC_W{1'b0}}}) - $signed({1'b0, acc_r});
    diff_pos_s = ~diff_s[DIFF_W-1] & (|diff_s);
    prod_s     = $signed(PROD_W'(diff_r)) * $signed(PROD_W'({1'b0, coef_sel_r}));
    step_raw_s = DIFF_W'(prod_s >>> COEF_W);
    step_s     = step_raw_s;
    if (hold_block_s) step_s = {DIFF_W{1'b0}};
    else              step_s = step_raw_s;
    sum_s      = $signed({2'b00, acc_r}) + SUM_W'(step_r);
    acc_nxt_s  = {ACC_W{1'b0}};
    if (sum_s[SUM_W-1])      acc_nxt_s = {ACC_W{1'b0}};
    else if (sum_s[ACC_W])   acc_nxt_s = {ACC_W{1'b1}};
    else                     acc_nxt_s = sum_s[ACC_W-1:0];
  end

  // Pipeline registers, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_r    <= {DATA_W{1'b0}};
      atk_r       <= {COEF_W{1'b0}};
      rel_r       <= {COEF_W{1'b0}};
      coef_sel_r  <= {COEF_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      diff_r      <= {DIFF_W{1'b0}};
      step_r      <= {DIFF_W{1'b0}};
      env_out_r   <= {DATA_W{1'b0}};
      env_valid_r <= 1'b0;
    end else begin
      env_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sample_r <= audio_in;
            atk_r    <= attack_coef;
            rel_r    <= release_coef;
          end
        end
        ABS: begin
          diff_r     <= diff_s;
          coef_sel_r <= diff_pos_s ? atk_r : rel_r;
        end
        MUL: step_r <= step_s;
        UPD: begin
          acc_r       <= acc_nxt_s;
          env_out_r   <= acc_nxt_s[ACC_W-1:FRAC_W];
          env_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ENV_PEAK_HOLD_EN
  logic [HOLD_W-1:0] hold_len_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  // Falling samples are frozen while the hold counter is still running.
  assign hold_block_s = diff_r[DIFF_W-1] & (|hold_cnt_r);

  // Hold counter: reloads on rising/equal samples, counts down on held falling ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_len_r <= {HOLD_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      if ((state_r == IDLE) && accept_s) hold_len_r <= hold_samples;
      if (state_r == UPD) begin
        if (!diff_r[DIFF_W-1])  hold_cnt_r <= hold_len_r;
        else if (|hold_cnt_r)   hold_cnt_r <= hold_cnt_r - HOLD_W'(1'b1);
        else                    hold_cnt_r <= hold_cnt_r;
      end
    end
  end
`else
  logic unused_hold_s;
  assign unused_hold_s = ^hold_samples;
  assign hold_block_s  = 1'b0;
`endif

  assign env_out   = env_out_r;
  assign env_valid = env_valid_r;

endmodule

// File: tb/tb_wdrc_envelope_detector.sv
// Self-checking bench for wdrc_envelope_detector: directed scenarios plus randomized
// samples compared against an arithmetic envelope model.
module tb_wdrc_envelope_detector;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] audio_in;
  logic [7:0]  attack_coef;
  logic [7:0]  release_coef;
  logic [11:0] hold_samples;
  logic        env_valid;
  logic [23:0] env_out;

  int          checks = 0;
  int          errors = 0;
  longint      m_acc  = 0;
  int          m_hold = 0;
  int          acc_cyc[$];
  int          pend_c;
  logic [23:0] pend_env;
  logic [23:0] env;
  logic [23:0] prev;
  logic [23:0] exp_env;
  logic [23:0] rx;

`ifdef ENV_PEAK_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  wdrc_envelope_detector #(.DATA_W(24), .FRAC_W(8), .COEF_W(8), .HOLD_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .audio_in     (audio_in),
    .attack_coef  (attack_coef),
    .release_coef (release_coef),
    .hold_samples (hold_samples),
    .env_valid    (env_valid),
    .env_out      (env_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Envelope in real-number terms: acc moves by floor(diff*coef/256), clamped to [0, 2^32-1].
  function automatic logic [23:0] model_env(input logic [23:0] x, input logic [7:0] a,
                                            input logic [7:0] r, input logic [11:0] h);
    logic signed [23:0] xs;
    longint xv, mag, diff, p, step;
    bit held;
    xs = x;
    xv = xs;
    mag = (xv < 0) ? -xv : xv;
    if (mag > 64'sd8388607) mag = 64'sd8388607;
    diff = mag * 256 - m_acc;
    p = diff * ((diff > 0) ? longint'(a) : longint'(r));
    step = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    held = 1'b0;
    if (diff >= 0) m_hold = int'(h);
    else if (m_hold != 0) begin
      held = 1'b1;
      m_hold--;
    end
    if (held && HOLD_EN) step = 0;
    m_acc = m_acc + step;
    if (m_acc < 0) m_acc = 0;
    if (m_acc > 64'sd4294967295) m_acc = 64'sd4294967295;
    return 24'(m_acc / 256);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] x, input logic [7:0] a, input logic [7:0] r,
                      input logic [11:0] h, input string tag, output logic [23:0] got);
    int w;
    logic [23:0] e;
    @(negedge clk);
    audio_in = x; attack_coef = a; release_coef = r; hold_samples = h; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    e = model_env(x, a, r, h);
    @(posedge clk); #1;
    in_valid = 1'b0;
    audio_in = $urandom; attack_coef = $urandom; release_coef = $urandom; hold_samples = $urandom;
    check({tag, " busy"}, 64'(in_ready), 64'd0);
    @(posedge clk); #1 check({tag, " pulse+1"}, 64'(env_valid), 64'd0);
    @(posedge clk); #1 check({tag, " pulse+2"}, 64'(env_valid), 64'd0);
    @(posedge clk); #1 check({tag, " pulse+3"}, 64'(env_valid), 64'd1);
    check({tag, " env"}, 64'(env_out), 64'(e));
    got = env_out;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1;
    audio_in = 24'h123456; attack_coef = 8'd10; release_coef = 8'd10; hold_samples = 12'd0;

    // Reset held 3 cycles with in_valid high.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst env_out", 64'(env_out), 64'd0);
      check("rst env_valid", 64'(env_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 check("rst released ready", 64'(in_ready), 64'd1);

    // diff = 0 takes release path with zero step.
    send(24'h000000, 8'd200, 8'd200, 12'd0, "zero diff", env);
    check("zero diff const", 64'(env), 64'h0);

    // Attack.
    send(24'h100000, 8'd128, 8'd0, 12'd0, "attack1", env);
    check("attack1 const", 64'(env), 64'h080000);
    send(24'h100000, 8'd128, 8'd0, 12'd0, "attack2", env);
    check("attack2 const", 64'(env), 64'h0C0000);

    // Release, then a negative sample above the envelope.
    send(24'h000000, 8'd7, 8'd1, 12'd0, "release", env);
    check("release const", 64'(env), 64'h0BF400);
    send(24'hF00000, 8'd64, 8'd1, 12'd0, "neg attack", env);
    check("neg attack const", 64'(env), 64'h0CF700);

    // Zero coefficient leaves the envelope untouched.
    send(24'h7FFFFF, 8'd0, 8'd0, 12'd0, "coef0", env);
    check("coef0 const", 64'(env), 64'h0CF700);

    // Saturation with the most negative input.
    prev = env;
    for (int i = 0; i < 8; i++) begin
      send(24'h800000, 8'd255, 8'd0, 12'd0, "sat", env);
      check("sat monotonic", 64'(env >= prev), 64'd1);
      check("sat ceiling", 64'(env <= 24'h7FFFFF), 64'd1);
      prev = env;
    end

    // Continuous in_valid: one acceptance every 4 cycles.
    pend_c = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      audio_in = $urandom; attack_coef = $urandom; release_coef = $urandom;
      hold_samples = 12'($urandom_range(0, 3)); in_valid = 1'b1;
      if (in_ready) begin
        acc_cyc.push_back(c);
        pend_c = c + 3;
        pend_env = model_env(audio_in, attack_coef, release_coef, hold_samples);
      end
      @(posedge clk); #1;
      check("stream valid", 64'(env_valid), 64'(c == pend_c));
      if (c == pend_c) check("stream env", 64'(env_out), 64'(pend_env));
    end
    in_valid = 1'b0;
    check("stream accepts", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("stream spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);

    // enable falls during MUL: result still delivered, nothing new accepted.
    @(negedge clk);
    audio_in = 24'h300000; attack_coef = 8'd100; release_coef = 8'd50; hold_samples = 12'd0;
    in_valid = 1'b1;
    check("en drop ready", 64'(in_ready), 64'd1);
    exp_env = model_env(audio_in, attack_coef, release_coef, hold_samples);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1 check("en drop pulse early", 64'(env_valid), 64'd0);
    @(posedge clk); #1 check("en drop pulse", 64'(env_valid), 64'd1);
    check("en drop env", 64'(env_out), 64'(exp_env));
    repeat (6) begin
      @(negedge clk) check("en drop no ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1 check("en drop no pulse", 64'(env_valid), 64'd0);
    end
    in_valid = 1'b0; enable = 1'b1;

    // Reset during MUL aborts the sample.
    @(negedge clk);
    audio_in = 24'h7FFFFF; attack_coef = 8'd255; release_coef = 8'd255; in_valid = 1'b1;
    check("rst mid ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst mid env", 64'(env_out), 64'd0);
    check("rst mid valid", 64'(env_valid), 64'd0);
    check("rst mid ready low", 64'(in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    m_acc = 0; m_hold = 0;
    repeat (3) begin
      @(posedge clk); #1 check("rst mid no pulse", 64'(env_valid), 64'd0);
    end
    check("rst mid env after", 64'(env_out), 64'd0);

    // Peak hold (or plain release when the hold feature is built out).
    send(24'h100000, 8'd128, 8'd0, 12'd2, "hold attack", env);
    check("hold attack const", 64'(env), 64'h080000);
    send(24'h000000, 8'd9, 8'd128, 12'd0, "hold rel1", env);
    check("hold rel1 const", 64'(env), HOLD_EN ? 64'h080000 : 64'h040000);
    send(24'h000000, 8'd9, 8'd128, 12'd0, "hold rel2", env);
    check("hold rel2 const", 64'(env), HOLD_EN ? 64'h080000 : 64'h020000);
    send(24'h000000, 8'd9, 8'd128, 12'd0, "hold rel3", env);
    check("hold rel3 const", 64'(env), HOLD_EN ? 64'h040000 : 64'h010000);

    // Randomized samples with occasional extreme codes and coefficients.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rx = 24'h800000;
        1:       rx = 24'h000000;
        2:       rx = 24'h7FFFFF;
        3:       rx = 24'($urandom_range(0, 255));
        default: rx = 24'($urandom);
      endcase
      send(rx, ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
           12'($urandom_range(0, 3)), "random", env);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
